// File: rtl/screen_sequencer_if.sv
// Pixel-side bundle between the sync generator/compositors, the screen
// sequencer and the DAC. The sequencer uses the master view; the
// surrounding video pipeline uses the slave view.
interface screen_sequencer_if;
    logic        video_on;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        start_sw;
    logic        game_over;
    logic [4:0]  title_rgb;
    logic [4:0]  game_rgb;
    logic [1:0]  frame_tick;
    logic        game_active;
    logic        game_reset;
    logic [4:0]  vga_rgb;

    modport master (
        input  video_on, pixel_x, pixel_y, start_sw, game_over, title_rgb, game_rgb,
        output frame_tick, game_active, game_reset, vga_rgb
    );

    modport slave (
        output video_on, pixel_x, pixel_y, start_sw, game_over, title_rgb, game_rgb,
        input  frame_tick, game_active, game_reset, vga_rgb
    );
endinterface

// File: rtl/screen_sequencer.sv
// Screen sequencer: frame-rate animation phase, debounced start from the
// title screen, play / game-over sequencing and the registered colour mux
// that feeds the DAC.
module screen_sequencer #(
    parameter int FRAMES_PER_TICK = 8,    // 1..255
    parameter int DEBOUNCE_FRAMES = 4,    // 1..15
    parameter int OVER_FRAMES     = 180   // 1..1023
) (
    input  logic                clk,
    input  logic                reset,
    screen_sequencer_if.master  bus
);

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        START = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // Terminal counts sized to the counters; counters stop one short of
    // these and jump back to zero, so they never exceed their range.
    localparam logic [7:0] FPT_L  = 8'(FRAMES_PER_TICK);
    localparam logic [3:0] DEB_L  = 4'(DEBOUNCE_FRAMES);
    localparam logic [9:0] OVER_L = 10'(OVER_FRAMES);

    state_t     state_q, state_d;
    logic       fb_q, fb_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [1:0] frame_tick_q, frame_tick_d;
    logic       arm_q, arm_d;
    logic [3:0] deb_q, deb_d;
    logic [9:0] over_q, over_d;
    logic [4:0] vga_q, vga_d;

    logic       frame_boundary;
    logic       frame_pulse;
    logic [4:0] rgb_sel;

    // Frame boundary edge detect and animation phase counter (runs in every state).
    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        frame_cnt_d    = frame_cnt_q;
        frame_tick_d   = frame_tick_q;
        frame_boundary = (bus.pixel_x == 11'd0) && (bus.pixel_y == 11'd480);
        frame_pulse    = frame_boundary && !fb_q;
        fb_d           = frame_boundary;
        if (frame_pulse) begin
            if (frame_cnt_q + 8'd1 == FPT_L) begin
                frame_cnt_d  = 8'd0;
                frame_tick_d = frame_tick_q + 2'd1;
            end else begin
                frame_cnt_d  = frame_cnt_q + 8'd1;
            end
        end
    end

    // Next-state logic: arming/debounce in TITLE, one-clk START, game-over hold.
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        deb_d   = deb_q;
        over_d  = over_q;
        case (state_q)
            TITLE: begin
                if (frame_pulse) begin
                    if (!bus.start_sw) begin
                        arm_d = 1'b1;
                        deb_d = 4'd0;
                    end else if (arm_q) begin
                        if (deb_q + 4'd1 == DEB_L) begin
                            state_d = START;
                            arm_d   = 1'b0;
                            deb_d   = 4'd0;
                        end else begin
                            deb_d   = deb_q + 4'd1;
                        end
                    end
                end
            end
            START: state_d = PLAY;
            PLAY: begin
                if (bus.game_over) begin
                    state_d = OVER;
                    over_d  = 10'd0;
                end
            end
            OVER: begin
                if (frame_pulse) begin
                    if (over_q + 10'd1 == OVER_L) begin
                        state_d = TITLE;
                        over_d  = 10'd0;
                    end else begin
                        over_d  = over_q + 10'd1;
                    end
                end
            end
            default: state_d = TITLE;
        endcase
    end

    // Colour source select and blanking ahead of the output register.
    always_comb begin
        rgb_sel = (state_q == TITLE) ? bus.title_rgb : bus.game_rgb;
        vga_d   = bus.video_on ? rgb_sel : 5'b00000;
    end

    // State registers with synchronous reset; the edge detector resets high so a
    // frame boundary present at reset release does not count as a new frame.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= TITLE;
            fb_q         <= 1'b1;
            frame_cnt_q  <= 8'd0;
            frame_tick_q <= 2'd0;
            arm_q        <= 1'b0;
            deb_q        <= 4'd0;
            over_q       <= 10'd0;
            vga_q        <= 5'b00000;
        end else begin
            state_q      <= state_d;
            fb_q         <= fb_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_tick_q <= frame_tick_d;
            arm_q        <= arm_d;
            deb_q        <= deb_d;
            over_q       <= over_d;
            vga_q        <= vga_d;
        end
    end

    assign bus.frame_tick  = frame_tick_q;
    assign bus.game_active = (state_q == PLAY);
    assign bus.game_reset  = (state_q == START);
    assign bus.vga_rgb     = vga_q;

endmodule

// File: doc/screen_sequencer.md
SCREEN_SEQUENCER -- requirements
Module: screen_sequencer

Interface
REQ-001 SHALL have parameter FRAMES_PER_TICK, default 8: frames per frame_tick increment (range 1..255).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 4: consecutive frame-boundary samples of start_sw high needed to start (range 1..15).
REQ-003 SHALL have parameter OVER_FRAMES, default 180: frames the game-over screen is held (range 1..1023).
REQ-004 SHALL have ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- video_on  in  1  visible-area flag from sync generator
- pixel_x  in  11  current column
- pixel_y  in  11  current row
- start_sw  in  1  start switch, already synchronised to clk
- game_over  in  1  level from game logic, sampled every clk
- title_rgb  in  5  title-screen colour (from title compositor)
- game_rgb  in  5  gameplay colour
- frame_tick  out  2  animation phase to title compositor
- game_active  out  1  high in PLAY
- game_reset  out  1  one-clk pulse on game start
- vga_rgb  out  5  registered pixel colour to DAC

Function
REQ-005 SHALL derive frame_pulse as a one-clk pulse on the rising edge of (pixel_x==0 && pixel_y==480), i.e. once per frame regardless of clk/pixel-rate ratio.
REQ-006 SHALL count frame_pulse in a frame counter; on reaching FRAMES_PER_TICK it SHALL reset to 0 and increment frame_tick modulo 4 (3 wraps to 0).
REQ-007 frame_tick SHALL advance in every state, not only TITLE.
REQ-008 SHALL implement FSM states TITLE, START, PLAY, OVER.
REQ-009 TITLE: an arm flag SHALL set when start_sw is sampled low on a frame_pulse; only while armed SHALL the debounce counter increment on each frame_pulse with start_sw high, clearing to 0 on any frame_pulse with start_sw low.
REQ-010 TITLE -> START when the debounce counter reaches DEBOUNCE_FRAMES; arm flag and debounce counter SHALL clear on this transition.
REQ-011 START SHALL last exactly one clk with game_reset=1, then -> PLAY unconditionally.
REQ-012 PLAY: game_active=1; -> OVER on the first clk game_over==1.
REQ-013 OVER: game_active=0; over counter increments per frame_pulse; -> TITLE when it reaches OVER_FRAMES; counter clears on entry.
REQ-014 game_over high in TITLE or START SHALL be ignored.
REQ-015 Colour select: TITLE -> title_rgb; START, PLAY, OVER -> game_rgb.
REQ-016 vga_rgb SHALL be registered: value at clk edge n+1 reflects video_on, select and inputs at edge n (latency 1 clk); video_on low SHALL force 5'b00000.
REQ-017 A state transition and a frame_pulse in the same clk SHALL both take effect (frame counter/frame_tick never stall).
REQ-018 Counters SHALL be wide enough for parameter maxima and SHALL never wrap past their terminal value.

Reset
REQ-019 reset high at a clk edge SHALL force: state=TITLE, frame_tick=0, frame counter=0, arm=0, debounce=0, over counter=0, game_active=0, game_reset=0, vga_rgb=0.
REQ-020 reset SHALL take priority over every other event, including mid-START (no game_reset pulse issued) and mid-OVER.
REQ-021 The frame_pulse edge detector register SHALL reset to 1 so a frame boundary coincident with reset release produces no pulse.

Verification
V1 Reset, then 32 frame_pulses, start_sw=0 -> frame_tick sequence 0,1,2,3,0 (changes after pulses 8,16,24,32); state stays TITLE.
V2 start_sw held high from reset for 20 frames -> never arms, stays TITLE; drop low 1 frame then high 4 frames -> game_reset one clk after 4th high pulse, game_active=1 next clk.
V3 Armed, start_sw pattern high,high,low,high,high,high,high -> start only after the final 4 consecutive highs.
V4 PLAY, game_over=1 -> game_active=0 next clk; after 180 frame_pulses state=TITLE, vga_rgb source returns to title_rgb; start_sw held high throughout -> no restart until low seen.
V5 title_rgb=5'b11000, video_on toggling -> vga_rgb=5'b11000 one clk after video_on=1, 5'b00000 one clk after video_on=0.
V6 reset asserted the clk state=START -> game_reset stays 0, state TITLE, all outputs 0.
